// File: rtl/msg_pkg.sv
// Shared definitions for the message transmit serializer and its receive-side peer.
package msg_pkg;

  localparam int DEF_MAX_MSG_BYTES = 32;
  localparam int DEF_DATA_BYTES    = 8;
  localparam int KEEP_MAX          = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    ABORT = 2'd2
  } txStateType;

  function automatic int len_w(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

  // Contiguous byte-qualifier mask; a zero remainder means a completely full beat.
  function automatic logic [KEEP_MAX-1:0] tkeep_for(input int unsigned rem,
                                                    input int unsigned width);
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_MAX; i++) begin
      m[i] = (rem == 0) ? (i < width) : (i < rem);
    end
    return m;
  endfunction

endpackage

// File: rtl/msg_serializer.sv
// Serializes one parallel message into AXI-Stream beats with tkeep/tlast/tuser.
// Handshake: a beat or message transfers on a clock edge where valid && ready; valid never drops without one.
module msg_serializer
  import msg_pkg::*;
#(
  parameter int MAX_MSG_BYTES = DEF_MAX_MSG_BYTES,
  parameter int DATA_BYTES    = DEF_DATA_BYTES,
  parameter int TKEEP_WIDTH   = DEF_DATA_BYTES,
  parameter int LEN_W         = len_w(MAX_MSG_BYTES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  input  logic [8*MAX_MSG_BYTES-1:0] msg_data,
  input  logic [LEN_W-1:0]           msg_len,
  input  logic                       msg_err,
  input  logic                       tx_abort,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [8*DATA_BYTES-1:0]    m_tdata,
  output logic [TKEEP_WIDTH-1:0]     m_tkeep,
  output logic                       m_tlast,
  output logic                       m_tuser,
  output txStateType                 dbg_state
);

  localparam int BEATS_MAX = (MAX_MSG_BYTES + DATA_BYTES - 1) / DATA_BYTES;
  localparam int BEAT_W    = $clog2(BEATS_MAX + 1);
  localparam int BEAT_BITS = 8 * DATA_BYTES;
  localparam int PAD_W     = BEAT_BITS * BEATS_MAX;

  if (TKEEP_WIDTH != DATA_BYTES) begin : g_keep_width_check
    $error("msg_serializer: TKEEP_WIDTH must equal DATA_BYTES");
  end

  txStateType                 r_state;
  logic [8*MAX_MSG_BYTES-1:0] r_msg;
  logic [LEN_W-1:0]           r_len;
  logic                       r_err;
  logic [BEAT_W-1:0]          r_beat;
  logic                       r_abort_pending;
  logic                       r_ready;
  logic                       r_tvalid;
  logic [BEAT_BITS-1:0]       r_tdata;
  logic [TKEEP_WIDTH-1:0]     r_tkeep;
  logic                       r_tlast;
  logic                       r_tuser;

  logic                       w_accept;
  logic                       w_beat_hs;
  logic [PAD_W-1:0]           w_src_pad;
  logic [LEN_W-1:0]           w_src_len;
  logic                       w_src_err;
  logic [BEAT_W-1:0]          w_src_idx;
  logic                       w_illegal;
  int                         w_len_i;
  int                         w_idx_i;
  int                         w_nbeats;
  int                         w_rem;
  logic                       w_nxt_last;
  logic [TKEEP_WIDTH-1:0]     w_nxt_keep;
  logic [BEAT_BITS-1:0]       w_nxt_data;
  logic                       w_nxt_user;

  assign w_accept  = msg_valid && r_ready;
  assign w_beat_hs = r_tvalid && m_tready;

  // The first beat is built straight from the offered message so it appears one edge after acceptance.
  always_comb begin
    w_src_pad = '0;
    w_src_pad[8*MAX_MSG_BYTES-1:0] = w_accept ? msg_data : r_msg;
    w_src_len  = w_accept ? msg_len : r_len;
    w_src_err  = w_accept ? msg_err : r_err;
    w_src_idx  = w_accept ? '0 : r_beat + 1'b1;
    w_len_i    = int'(w_src_len);
    w_idx_i    = int'(w_src_idx);
    w_illegal  = (w_len_i == 0) || (w_len_i > MAX_MSG_BYTES);
    w_nbeats   = (w_len_i + DATA_BYTES - 1) / DATA_BYTES;
    w_rem      = w_len_i % DATA_BYTES;
    w_nxt_last = w_illegal || (w_idx_i == w_nbeats - 1);
    if (w_illegal) begin
      w_nxt_keep = '0;
    end else if (w_nxt_last) begin
      w_nxt_keep = TKEEP_WIDTH'(tkeep_for(unsigned'(w_rem), DATA_BYTES));
    end else begin
      w_nxt_keep = '1;
    end
    w_nxt_data = w_src_pad[w_idx_i*BEAT_BITS +: BEAT_BITS];
    for (int j = 0; j < DATA_BYTES; j++) begin
      if (!w_nxt_keep[j]) w_nxt_data[8*j +: 8] = '0;
    end
    w_nxt_user = w_illegal || (w_nxt_last && w_src_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_msg           <= '0;
      r_len           <= '0;
      r_err           <= 1'b0;
      r_beat          <= '0;
      r_abort_pending <= 1'b0;
      r_ready         <= 1'b0;
      r_tvalid        <= 1'b0;
      r_tdata         <= '0;
      r_tkeep         <= '0;
      r_tlast         <= 1'b0;
      r_tuser         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready         <= 1'b1;
          r_abort_pending <= 1'b0;
          if (w_accept) begin
            r_msg    <= msg_data;
            r_len    <= msg_len;
            r_err    <= msg_err;
            r_beat   <= '0;
            r_ready  <= 1'b0;
            r_tvalid <= 1'b1;
            r_tdata  <= w_nxt_data;
            r_tkeep  <= w_nxt_keep;
            r_tlast  <= w_nxt_last;
            r_tuser  <= w_nxt_user;
            r_state  <= SEND;
          end
        end
        SEND: begin
          if (!w_beat_hs) begin
            r_abort_pending <= r_abort_pending || tx_abort;
          end else if (r_tlast) begin
            r_abort_pending <= 1'b0;
            r_tvalid        <= 1'b0;
            r_tdata         <= '0;
            r_tkeep         <= '0;
            r_tlast         <= 1'b0;
            r_tuser         <= 1'b0;
            r_ready         <= 1'b1;
            r_state         <= IDLE;
          end else if (r_abort_pending || tx_abort) begin
            r_abort_pending <= 1'b0;
            r_tdata         <= '0;
            r_tkeep         <= '0;
            r_tlast         <= 1'b1;
            r_tuser         <= 1'b1;
            r_state         <= ABORT;
          end else begin
            r_beat  <= w_src_idx;
            r_tdata <= w_nxt_data;
            r_tkeep <= w_nxt_keep;
            r_tlast <= w_nxt_last;
            r_tuser <= w_nxt_user;
          end
        end
        ABORT: begin
          if (w_beat_hs) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_tuser  <= 1'b0;
            r_ready  <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign msg_ready = r_ready;
  assign m_tvalid  = r_tvalid;
  assign m_tdata   = r_tdata;
  assign m_tkeep   = r_tkeep;
  assign m_tlast   = r_tlast;
  assign m_tuser   = r_tuser;
  assign dbg_state = r_state;

endmodule
